// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM BIST master: controller states and the write-data pattern.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWrite = 3'd1,
        StRead  = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } bist_state_e;

    // Full-width product; callers truncate to their data width.
    function automatic logic [31:0] bist_pattern(input logic [31:0] addr, input int unsigned mult);
        return addr * mult;
    endfunction

endpackage

// File: rtl/ram_bist_rdpipe.sv
// Read-side delay line matching RAM latency, with data compare and first-failure capture.
module ram_bist_rdpipe
    import ram_bist_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MULT     = 10,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [DATA_W-1:0] first_fail_data
);

    localparam logic [ADDR_W:0] ErrOne = (ADDR_W + 1)'(1);

    logic              emerge_valid;
    logic [ADDR_W-1:0] emerge_addr;
    logic [DATA_W-1:0] expected;
    logic              mismatch;

    logic [ADDR_W:0]   err_q;
    logic [ADDR_W-1:0] ffa_q;
    logic [DATA_W-1:0] ffd_q;

    if (READ_LAT == 0) begin : g_nolat
        assign emerge_valid = rd_valid;
        assign emerge_addr  = rd_addr;
    end else begin : g_lat
        logic [READ_LAT-1:0] vld_q;
        logic [ADDR_W-1:0]   addr_q [READ_LAT];

        always_ff @(posedge clk) begin
            if (reset || clear) begin
                vld_q <= '0;
                for (int i = 0; i < int'(READ_LAT); i++) begin
                    addr_q[i] <= '0;
                end
            end else begin
                vld_q[0]  <= rd_valid;
                addr_q[0] <= rd_addr;
                for (int i = 1; i < int'(READ_LAT); i++) begin
                    vld_q[i]  <= vld_q[i-1];
                    addr_q[i] <= addr_q[i-1];
                end
            end
        end

        assign emerge_valid = vld_q[READ_LAT-1];
        assign emerge_addr  = addr_q[READ_LAT-1];
    end

    assign expected = DATA_W'(bist_pattern(32'(emerge_addr), MULT));
    assign mismatch = emerge_valid && (mem_data_out != expected);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            err_q <= '0;
            ffa_q <= '0;
            ffd_q <= '0;
        end else if (mismatch) begin
            err_q <= err_q + ErrOne;
            if (err_q == '0) begin
                ffa_q <= emerge_addr;
                ffd_q <= mem_data_out;
            end
        end
    end

    assign err_count       = err_q;
    assign first_fail_addr = ffa_q;
    assign first_fail_data = ffd_q;

endmodule

// File: rtl/ram_bist_master.sv
// BIST master: writes a multiplicative pattern to every RAM address, then reads back and compares.
module ram_bist_master
    import ram_bist_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MULT     = 10,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_wr,
    output logic              mem_cs,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [DATA_W-1:0] first_fail_data
);

    localparam logic [ADDR_W-1:0] KLast     = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] KOne      = ADDR_W'(1);
    localparam logic [1:0]        DrainLast = (READ_LAT > 0) ? 2'(READ_LAT - 1) : 2'd0;

    bist_state_e       state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [1:0]        drain_q, drain_d;
    logic              clear;
    logic              rd_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        drain_d     = drain_q;
        clear       = 1'b0;
        rd_valid    = 1'b0;
        mem_cs      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StWrite;
                    k_d     = '0;
                    clear   = 1'b1;
                end
            end
            StWrite: begin
                mem_cs      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = k_q;
                mem_data_in = DATA_W'(bist_pattern(32'(k_q), MULT));
                if (k_q == KLast) begin
                    state_d = StRead;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KOne;
                end
            end
            StRead: begin
                mem_cs   = 1'b1;
                mem_addr = k_q;
                rd_valid = 1'b1;
                if (k_q == KLast) begin
                    state_d = (READ_LAT > 0) ? StDrain : StDone;
                    k_d     = '0;
                    drain_d = '0;
                end else begin
                    k_d = k_q + KOne;
                end
            end
            StDrain: begin
                // Keep the RAM selected until the last in-flight read has been compared.
                mem_cs   = 1'b1;
                mem_addr = KLast;
                if (drain_q == DrainLast) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    ram_bist_rdpipe #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MULT    (MULT),
        .READ_LAT(READ_LAT)
    ) u_rdpipe (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .rd_valid       (rd_valid),
        .rd_addr        (k_q),
        .mem_data_out   (mem_data_out),
        .err_count      (err_count),
        .first_fail_addr(first_fail_addr),
        .first_fail_data(first_fail_data)
    );

    assign busy = (state_q == StWrite) || (state_q == StRead) || (state_q == StDrain);
    assign done = (state_q == StDone);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_ram_bist_master.sv
// Directed bench: four BIST instances with different geometry/latency against behavioural RAMs.
module tb_ram_bist_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: ADDR_W=4, READ_LAT=1, registered RAM with optional stuck-at fault.
    logic       rst_a = 1'b1, start_a = 1'b0, fault_a = 1'b0;
    logic [3:0] a_addr, a_ffa;
    logic [7:0] a_din, a_dout, a_ffd;
    logic       a_wr, a_cs, a_busy, a_done, a_pass;
    logic [4:0] a_err;
    logic [7:0] ram_a [16];

    // Instances B (ADDR_W=5), C (READ_LAT=0), D (READ_LAT=3) share start/reset.
    logic       rst_o = 1'b1, start_o = 1'b0;
    logic [4:0] b_addr, b_ffa;
    logic [7:0] b_din, b_dout, b_ffd;
    logic       b_wr, b_cs, b_busy, b_done, b_pass;
    logic [5:0] b_err;
    logic [7:0] ram_b [32];
    logic [3:0] c_addr, c_ffa, d_addr, d_ffa;
    logic [7:0] c_din, c_dout, c_ffd, d_din, d_dout, d_ffd;
    logic       c_wr, c_cs, c_busy, c_done, c_pass, d_wr, d_cs, d_busy, d_done, d_pass;
    logic [4:0] c_err, d_err;
    logic [7:0] ram_c [16];
    logic [7:0] ram_d [16];
    logic [7:0] d_p1, d_p2, d_p3;

    ram_bist_master #(.ADDR_W(4), .DATA_W(8), .MULT(10), .READ_LAT(1)) u_a (
        .clk(clk), .reset(rst_a), .start(start_a), .mem_addr(a_addr), .mem_data_in(a_din),
        .mem_wr(a_wr), .mem_cs(a_cs), .mem_data_out(a_dout), .busy(a_busy), .done(a_done),
        .pass(a_pass), .err_count(a_err), .first_fail_addr(a_ffa), .first_fail_data(a_ffd)
    );
    ram_bist_master #(.ADDR_W(5), .DATA_W(8), .MULT(10), .READ_LAT(1)) u_b (
        .clk(clk), .reset(rst_o), .start(start_o), .mem_addr(b_addr), .mem_data_in(b_din),
        .mem_wr(b_wr), .mem_cs(b_cs), .mem_data_out(b_dout), .busy(b_busy), .done(b_done),
        .pass(b_pass), .err_count(b_err), .first_fail_addr(b_ffa), .first_fail_data(b_ffd)
    );
    ram_bist_master #(.ADDR_W(4), .DATA_W(8), .MULT(10), .READ_LAT(0)) u_c (
        .clk(clk), .reset(rst_o), .start(start_o), .mem_addr(c_addr), .mem_data_in(c_din),
        .mem_wr(c_wr), .mem_cs(c_cs), .mem_data_out(c_dout), .busy(c_busy), .done(c_done),
        .pass(c_pass), .err_count(c_err), .first_fail_addr(c_ffa), .first_fail_data(c_ffd)
    );
    ram_bist_master #(.ADDR_W(4), .DATA_W(8), .MULT(10), .READ_LAT(3)) u_d (
        .clk(clk), .reset(rst_o), .start(start_o), .mem_addr(d_addr), .mem_data_in(d_din),
        .mem_wr(d_wr), .mem_cs(d_cs), .mem_data_out(d_dout), .busy(d_busy), .done(d_done),
        .pass(d_pass), .err_count(d_err), .first_fail_addr(d_ffa), .first_fail_data(d_ffd)
    );

    always @(posedge clk) begin
        if (a_cs && a_wr) ram_a[a_addr] <= a_din;
        if (a_cs && !a_wr) a_dout <= ram_a[a_addr] | {7'd0, fault_a && (a_addr == 4'd5)};
        if (b_cs && b_wr) ram_b[b_addr] <= b_din;
        if (b_cs && !b_wr) b_dout <= ram_b[b_addr];
        if (c_cs && c_wr) ram_c[c_addr] <= c_din;
        if (d_cs && d_wr) ram_d[d_addr] <= d_din;
        d_p1 <= ram_d[d_addr];
        d_p2 <= d_p1;
        d_p3 <= d_p2;
    end
    assign c_dout = ram_c[c_addr];
    assign d_dout = d_p3;

    // Observations from the most recent run of instance A, indexed by cycle after start.
    logic [3:0] log_addr [32];
    logic [7:0] log_data [32];
    logic       log_cs   [32];
    logic       log_wr   [32];
    logic       busy_e1, busy_e33;

    logic [7:0] exp_wdata [16] = '{8'h00, 8'h0A, 8'h14, 8'h1E, 8'h28, 8'h32, 8'h3C, 8'h46,
                                   8'h50, 8'h5A, 8'h64, 8'h6E, 8'h78, 8'h82, 8'h8C, 8'h96};

    // start is driven just after edge 0 of the run; glitch_edge adds a second pulse mid-pass.
    task automatic run_a(input int glitch_edge, output int done_edge);
        done_edge = -1;
        @(posedge clk); #1 start_a = 1'b1;
        for (int e = 1; e <= 80; e++) begin
            @(posedge clk); #1;
            start_a = (e == glitch_edge);
            if (e <= 32) begin
                log_addr[e-1] = a_addr;
                log_data[e-1] = a_din;
                log_cs[e-1]   = a_cs;
                log_wr[e-1]   = a_wr;
            end
            if (e == 1)  busy_e1  = a_busy;
            if (e == 33) busy_e33 = a_busy;
            if (a_done) begin
                done_edge = e;
                break;
            end
        end
        start_a = 1'b0;
    endtask

    task automatic run_o(output int b_de, output int c_de, output int d_de,
                         output logic [4:0] b_a26, output logic [7:0] b_d26);
        b_de = -1; c_de = -1; d_de = -1;
        @(posedge clk); #1 start_o = 1'b1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk); #1;
            start_o = 1'b0;
            if (e == 27) begin
                b_a26 = b_addr;
                b_d26 = b_din;
            end
            if (b_done && b_de < 0) b_de = e;
            if (c_done && c_de < 0) c_de = e;
            if (d_done && d_de < 0) d_de = e;
            if (b_de >= 0 && c_de >= 0 && d_de >= 0) break;
        end
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        obs = {a_addr, a_din, a_ffa, a_ffd, a_err, a_wr, a_cs, a_busy};
        total++;
        if (obs !== 32'd0) begin
            bad++; $display("FAIL reset_outputs got %h want 0", obs);
        end
        total++;
        if ({a_done, a_pass} !== 2'b00) begin
            bad++; $display("FAIL reset_done_pass got %b want 00", {a_done, a_pass});
        end
    endtask

    task automatic test_pattern();
        int de;
        run_a(-1, de);
        for (int i = 0; i < 16; i++) begin
            total++;
            if ({log_cs[i], log_wr[i], log_addr[i], log_data[i]} !== {2'b11, 4'(i), exp_wdata[i]})
            begin
                bad++;
                $display("FAIL write_%0d got cs=%b wr=%b a=%h d=%h want cs=1 wr=1 a=%h d=%h", i,
                         log_cs[i], log_wr[i], log_addr[i], log_data[i], 4'(i), exp_wdata[i]);
            end
            total++;
            if ({log_cs[16+i], log_wr[16+i], log_addr[16+i], log_data[16+i]} !==
                {2'b10, 4'(i), 8'h00}) begin
                bad++;
                $display("FAIL read_%0d got cs=%b wr=%b a=%h d=%h want cs=1 wr=0 a=%h d=00", i,
                         log_cs[16+i], log_wr[16+i], log_addr[16+i], log_data[16+i], 4'(i));
            end
        end
        total++;
        if (de !== 34) begin bad++; $display("FAIL done_edge got %0d want 34", de); end
        total++;
        if ({busy_e1, busy_e33} !== 2'b11) begin
            bad++; $display("FAIL busy_window got %b want 11", {busy_e1, busy_e33});
        end
        total++;
        if ({a_pass, a_busy, a_cs, a_err} !== {3'b100, 5'd0}) begin
            bad++; $display("FAIL clean_status got p=%b b=%b cs=%b e=%0d want p=1 b=0 cs=0 e=0",
                            a_pass, a_busy, a_cs, a_err);
        end
    endtask

    task automatic test_fault();
        int de;
        fault_a = 1'b1;
        run_a(-1, de);
        fault_a = 1'b0;
        total++;
        if (de !== 34) begin bad++; $display("FAIL fault_done_edge got %0d want 34", de); end
        total++;
        if (a_err !== 5'd1) begin bad++; $display("FAIL fault_err got %0d want 1", a_err); end
        total++;
        if (a_ffa !== 4'd5) begin bad++; $display("FAIL fault_addr got %h want 5", a_ffa); end
        total++;
        if (a_ffd !== 8'h33) begin bad++; $display("FAIL fault_data got %h want 33", a_ffd); end
        total++;
        if (a_pass !== 1'b0) begin bad++; $display("FAIL fault_pass got %b want 0", a_pass); end
    endtask

    task automatic test_start_ignored();
        int de;
        run_a(10, de);
        for (int i = 0; i < 32; i++) begin
            total++;
            if (log_addr[i] !== 4'(i % 16)) begin
                bad++;
                $display("FAIL glitch_addr_%0d got %h want %h", i, log_addr[i], 4'(i % 16));
            end
        end
        total++;
        if (de !== 34) begin bad++; $display("FAIL glitch_done_edge got %0d want 34", de); end
        total++;
        if (a_pass !== 1'b1) begin bad++; $display("FAIL glitch_pass got %b want 1", a_pass); end
    endtask

    task automatic test_reset_mid_pass();
        int de;
        logic [31:0] obs;
        fault_a = 1'b1;
        run_a(-1, de);
        total++;
        if (a_err !== 5'd1) begin bad++; $display("FAIL pre_reset_err got %0d want 1", a_err); end
        @(posedge clk); #1 start_a = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            if (e == 20) rst_a = 1'b1;
        end
        @(posedge clk); #1;
        obs = {a_addr, a_din, a_ffa, a_ffd, a_err, a_wr, a_cs, a_busy};
        total++;
        if (obs !== 32'd0) begin
            bad++; $display("FAIL midreset_outputs got %h want 0", obs);
        end
        total++;
        if ({a_done, a_pass} !== 2'b00) begin
            bad++; $display("FAIL midreset_done_pass got %b want 00", {a_done, a_pass});
        end
        rst_a = 1'b0;
        fault_a = 1'b0;
        run_a(-1, de);
        total++;
        if (de !== 34) begin bad++; $display("FAIL fresh_done_edge got %0d want 34", de); end
        total++;
        if ({a_pass, a_err} !== {1'b1, 5'd0}) begin
            bad++; $display("FAIL fresh_status got p=%b e=%0d want p=1 e=0", a_pass, a_err);
        end
    endtask

    task automatic test_wide_pattern();
        int bde, cde, dde;
        logic [4:0] a26;
        logic [7:0] d26;
        run_o(bde, cde, dde, a26, d26);
        total++;
        if ({a26, d26} !== {5'd26, 8'h04}) begin
            bad++; $display("FAIL wide_addr26 got a=%0d d=%h want a=26 d=04", a26, d26);
        end
        total++;
        if (bde !== 66) begin bad++; $display("FAIL wide_done_edge got %0d want 66", bde); end
        total++;
        if ({b_pass, b_err} !== {1'b1, 6'd0}) begin
            bad++; $display("FAIL wide_status got p=%b e=%0d want p=1 e=0", b_pass, b_err);
        end
    endtask

    task automatic test_read_latency();
        int bde, cde, dde;
        logic [4:0] a26;
        logic [7:0] d26;
        run_o(bde, cde, dde, a26, d26);
        total++;
        if (cde !== 33) begin bad++; $display("FAIL lat0_done_edge got %0d want 33", cde); end
        total++;
        if (dde !== 36) begin bad++; $display("FAIL lat3_done_edge got %0d want 36", dde); end
        total++;
        if ({c_pass, c_err} !== {1'b1, 5'd0}) begin
            bad++; $display("FAIL lat0_status got p=%b e=%0d want p=1 e=0", c_pass, c_err);
        end
        total++;
        if ({d_pass, d_err} !== {1'b1, 5'd0}) begin
            bad++; $display("FAIL lat3_status got p=%b e=%0d want p=1 e=0", d_pass, d_err);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_a = 1'b0;
        rst_o = 1'b0;
        test_pattern();
        test_fault();
        test_start_ignored();
        test_reset_mid_pass();
        test_wide_pattern();
        test_read_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
